ff_conv_bank: RTL and testbench

Parametrised bank of WIDTH independently configurable flip-flops. Each lane is programmed at run time to behave as a D, T, JK or SR flip-flop. Next state is computed from the lane's two generic inputs (a, b) and its current state. This block generalises the single-bit D-to-JK converter into a multi-lane, multi-mode register. It adds SR-illegal error flags and a change counter for debug.

---
 rtl/ff_conv_pkg.sv | 44 ++++
 rtl/ff_conv_lane.sv | 67 ++++++
 rtl/ff_conv_bank.sv | 81 ++++++++
 tb/tb_ff_conv_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ff_conv_pkg.sv
// Shared types and the per-lane next-state function for the flip-flop bank.
package ff_conv_pkg;

    typedef enum logic [1:0] {
        MODE_D  = 2'b00,
        MODE_T  = 2'b01,
        MODE_JK = 2'b10,
        MODE_SR = 2'b11
    } mode_e;

    // Result of one lane evaluation: the candidate next state and whether the
    // inputs form the illegal S=R=1 combination in SR mode.
    typedef struct packed {
        logic q_next;
        logic illegal;
    } lane_next_t;

    // a carries D/T/J/S and b carries K/R, depending on the lane mode.
    function automatic lane_next_t lane_next(input mode_e mode, input logic a,
                                             input logic b, input logic q);
        lane_next_t r;
        r.q_next  = q;
        r.illegal = 1'b0;
        case (mode)
            MODE_D:  r.q_next = a;
            MODE_T:  r.q_next = q ^ a;
            MODE_JK: r.q_next = (a & ~q) | (~b & q);
            MODE_SR: begin
                case ({a, b})
                    2'b10:   r.q_next = 1'b1;
                    2'b01:   r.q_next = 1'b0;
                    2'b11: begin
                        r.q_next  = q;
                        r.illegal = 1'b1;
                    end
                    default: r.q_next = q;
                endcase
            end
            default: r.q_next = q;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ff_conv_lane.sv
// One lane of the bank: next-state logic plus the lane's q, mode and sticky
// SR error registers. o_change tells the top level this lane will flip q at
// the coming edge, so the bank can count changes without a second q copy.
module ff_conv_lane
    import ff_conv_pkg::*;
#(
    parameter logic       RESET_BIT    = 1'b0,
    parameter logic [1:0] DEFAULT_MODE = 2'b00
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  i_en,
    input  logic  i_a,
    input  logic  i_b,
    input  logic  i_mode_we,
    input  mode_e i_mode_wdata,
    input  logic  i_err_clr,
    output logic  o_q,
    output mode_e o_mode,
    output logic  o_sr_err,
    output logic  o_change
);

    logic       r_q;
    mode_e      r_mode;
    logic       r_sr_err;
    lane_next_t w_next;

    // Evaluated with the current mode, so a mode write at this edge only
    // affects behaviour from the following edge.
    assign w_next   = lane_next(r_mode, i_a, i_b, r_q);
    assign o_change = i_en & (w_next.q_next ^ r_q);

    // Lane state update, gated by the bank enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RESET_BIT;
        end else if (i_en) begin
            r_q <= w_next.q_next;
        end
    end

    // Mode register; writes never touch q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode <= mode_e'(DEFAULT_MODE);
        end else if (i_mode_we) begin
            r_mode <= i_mode_wdata;
        end
    end

    // Sticky SR error; a new illegal condition beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr_err <= 1'b0;
        end else if (i_en && w_next.illegal) begin
            r_sr_err <= 1'b1;
        end else if (i_err_clr) begin
            r_sr_err <= 1'b0;
        end
    end

    assign o_q      = r_q;
    assign o_mode   = r_mode;
    assign o_sr_err = r_sr_err;

endmodule

// File: rtl/ff_conv_bank.sv
// Bank of WIDTH run-time configurable flip-flops (D/T/JK/SR per lane) with
// sticky SR error flags and a saturating change counter for debug.
//
// cfg_we is a single-cycle write strobe with no backpressure: the mode write
// is taken at every edge where cfg_we=1 and cfg_lane addresses a real lane;
// out-of-range lane indices are silently dropped.
module ff_conv_bank
    import ff_conv_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VAL    = '0,
    parameter logic [1:0]       DEFAULT_MODE = 2'b00,
    parameter int               CNT_W        = 16,
    localparam int              CFG_W        = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               cfg_we,
    input  logic [CFG_W-1:0]   cfg_lane,
    input  logic [1:0]         cfg_mode,
    input  logic               err_clr,
    output logic [WIDTH-1:0]   q,
    output logic [WIDTH-1:0]   qn,
    output logic [2*WIDTH-1:0] mode_q,
    output logic [WIDTH-1:0]   sr_err,
    output logic [CNT_W-1:0]   chg_cnt
);

    localparam logic [CFG_W:0] LANE_LIMIT = (CFG_W + 1)'(WIDTH);

    logic             w_cfg_ok;
    logic [WIDTH-1:0] w_lane_we;
    logic [WIDTH-1:0] w_change;
    logic [CNT_W-1:0] r_chg_cnt;

    // Ignore writes whose lane index is beyond the last lane.
    assign w_cfg_ok = cfg_we && ({1'b0, cfg_lane} < LANE_LIMIT);

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        mode_e w_mode;

        assign w_lane_we[i] = w_cfg_ok && (cfg_lane == CFG_W'(i));

        ff_conv_lane #(
            .RESET_BIT    (RESET_VAL[i]),
            .DEFAULT_MODE (DEFAULT_MODE)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_en         (en),
            .i_a          (a[i]),
            .i_b          (b[i]),
            .i_mode_we    (w_lane_we[i]),
            .i_mode_wdata (mode_e'(cfg_mode)),
            .i_err_clr    (err_clr),
            .o_q          (q[i]),
            .o_mode       (w_mode),
            .o_sr_err     (sr_err[i]),
            .o_change     (w_change[i])
        );

        assign mode_q[2*i +: 2] = w_mode;
    end

    assign qn = ~q;

    // Count enabled edges where any lane flips; hold at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chg_cnt <= '0;
        end else if ((|w_change) && (r_chg_cnt != {CNT_W{1'b1}})) begin
            r_chg_cnt <= r_chg_cnt + CNT_W'(1);
        end
    end

    assign chg_cnt = r_chg_cnt;

endmodule

// File: tb/tb_ff_conv_bank.sv
// Directed bench for ff_conv_bank: a WIDTH=8/CNT_W=16 instance for the mode
// behaviour and a WIDTH=6/CNT_W=2 instance for out-of-range lane writes,
// enable gating and counter saturation.
module tb_ff_conv_bank;

    logic        clk;
    logic        rst_n;

    // Main instance
    logic        en;
    logic [7:0]  a, b;
    logic        cfg_we;
    logic [2:0]  cfg_lane;
    logic [1:0]  cfg_mode;
    logic        err_clr;
    logic [7:0]  q, qn, sr_err;
    logic [15:0] mode_q;
    logic [15:0] chg_cnt;

    // Small instance
    logic        d2_en;
    logic [5:0]  d2_a, d2_b;
    logic        d2_cfg_we;
    logic [2:0]  d2_cfg_lane;
    logic [1:0]  d2_cfg_mode;
    logic        d2_err_clr;
    logic [5:0]  d2_q, d2_qn, d2_sr_err;
    logic [11:0] d2_mode_q;
    logic [1:0]  d2_chg_cnt;

    int n_checks;
    int n_errors;

    ff_conv_bank #(.WIDTH(8), .RESET_VAL(8'h00), .DEFAULT_MODE(2'b00), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b),
        .cfg_we(cfg_we), .cfg_lane(cfg_lane), .cfg_mode(cfg_mode), .err_clr(err_clr),
        .q(q), .qn(qn), .mode_q(mode_q), .sr_err(sr_err), .chg_cnt(chg_cnt)
    );

    ff_conv_bank #(.WIDTH(6), .RESET_VAL(6'h00), .DEFAULT_MODE(2'b00), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .en(d2_en), .a(d2_a), .b(d2_b),
        .cfg_we(d2_cfg_we), .cfg_lane(d2_cfg_lane), .cfg_mode(d2_cfg_mode), .err_clr(d2_err_clr),
        .q(d2_q), .qn(d2_qn), .mode_q(d2_mode_q), .sr_err(d2_sr_err), .chg_cnt(d2_chg_cnt)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then sit 1ns after it for sampling and driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [2:0] lane, input logic [1:0] mode);
        en       = 1'b0;
        cfg_we   = 1'b1;
        cfg_lane = lane;
        cfg_mode = mode;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic d2_cfg_write(input logic [2:0] lane, input logic [1:0] mode);
        d2_cfg_we   = 1'b1;
        d2_cfg_lane = lane;
        d2_cfg_mode = mode;
        tick();
        d2_cfg_we   = 1'b0;
    endtask

    // Drive a/b with en=1 for one edge and check the resulting q.
    task automatic step_q(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic [7:0] exp_q);
        en = 1'b1;
        a  = av;
        b  = bv;
        tick();
        check(tag, 32'(q), 32'(exp_q));
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        en = 1'b0; a = '0; b = '0; cfg_we = 1'b0; cfg_lane = '0; cfg_mode = '0; err_clr = 1'b0;
        d2_en = 1'b0; d2_a = '0; d2_b = '0; d2_cfg_we = 1'b0; d2_cfg_lane = '0;
        d2_cfg_mode = '0; d2_err_clr = 1'b0;

        #3;
        check("por_q", 32'(q), 32'h00);
        check("por_mode", 32'(mode_q), 32'h0000);
        check("por_cnt", 32'(chg_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // D/T mix: lane1 = T, everything else D
        cfg_write(3'd1, 2'b01);
        check("cfg_lane1_T", 32'(mode_q), 32'h0004);
        step_q("dt_edge1", 8'h03, 8'h00, 8'h03);
        check("dt_qn", 32'(qn), 32'hFC);
        step_q("dt_edge2", 8'h02, 8'h00, 8'h00);
        check("dt_cnt", 32'(chg_cnt), 32'd2);

        // JK truth table on lane2
        cfg_write(3'd2, 2'b10);
        step_q("jk_set",     8'h04, 8'h00, 8'h04);
        step_q("jk_hold",    8'h00, 8'h00, 8'h04);
        step_q("jk_toggle0", 8'h04, 8'h04, 8'h00);
        step_q("jk_toggle1", 8'h04, 8'h04, 8'h04);
        step_q("jk_reset",   8'h00, 8'h04, 8'h00);
        check("jk_cnt", 32'(chg_cnt), 32'd6);

        // SR on lane3, including the illegal combination
        cfg_write(3'd3, 2'b11);
        step_q("sr_set", 8'h08, 8'h00, 8'h08);
        step_q("sr_illegal_hold", 8'h08, 8'h08, 8'h08);
        check("sr_err_set", 32'(sr_err), 32'h08);
        check("sr_cnt_hold", 32'(chg_cnt), 32'd7);
        err_clr = 1'b1;
        step_q("sr_illegal_clr_q", 8'h08, 8'h08, 8'h08);
        check("sr_err_set_wins", 32'(sr_err), 32'h08);
        step_q("sr_hold_clr_q", 8'h00, 8'h00, 8'h08);
        check("sr_err_cleared", 32'(sr_err), 32'h00);
        err_clr = 1'b0;
        en = 1'b0; a = 8'h08; b = 8'h08;
        tick();
        check("sr_err_en0", 32'(sr_err), 32'h00);
        check("sr_q_en0", 32'(q), 32'h08);
        step_q("sr_reset", 8'h00, 8'h08, 8'h00);
        check("sr_cnt", 32'(chg_cnt), 32'd8);

        // Config timing on lane4
        step_q("cfg_setup_q4", 8'h10, 8'h00, 8'h10);
        cfg_we = 1'b1; cfg_lane = 3'd4; cfg_mode = 2'b01;
        step_q("cfg_old_mode", 8'h10, 8'h00, 8'h10);
        cfg_we = 1'b0;
        check("cfg_mode_all", 32'(mode_q), 32'h01E4);
        step_q("cfg_new_mode", 8'h10, 8'h00, 8'h00);
        check("cfg_cnt", 32'(chg_cnt), 32'd10);

        // Asynchronous reset mid-cycle with q and sr_err nonzero
        step_q("pre_rst_q", 8'h09, 8'h08, 8'h01);
        check("pre_rst_err", 32'(sr_err), 32'h08);
        check("pre_rst_cnt", 32'(chg_cnt), 32'd11);
        en = 1'b0; a = '0; b = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_q", 32'(q), 32'h00);
        check("arst_qn", 32'(qn), 32'hFF);
        check("arst_mode", 32'(mode_q), 32'h0000);
        check("arst_err", 32'(sr_err), 32'h00);
        check("arst_cnt", 32'(chg_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Out-of-range lane writes on the 6-lane instance
        d2_cfg_write(3'd6, 2'b01);
        check("oor_lane6", 32'(d2_mode_q), 32'h000);
        d2_cfg_write(3'd7, 2'b11);
        check("oor_lane7", 32'(d2_mode_q), 32'h000);
        d2_cfg_write(3'd5, 2'b01);
        check("inr_lane5", 32'(d2_mode_q), 32'h400);

        // Enable gating: inputs toggle, nothing moves
        d2_en = 1'b0;
        d2_a = 6'h1F; tick();
        d2_a = 6'h00; tick();
        d2_a = 6'h1F; tick();
        check("en0_q", 32'(d2_q), 32'h00);
        check("en0_cnt", 32'(d2_chg_cnt), 32'd0);

        // Saturation of the 2-bit counter
        d2_en = 1'b1;
        d2_a = 6'h01; tick(); check("sat_c1", 32'(d2_chg_cnt), 32'd1);
        d2_a = 6'h00; tick(); check("sat_c2", 32'(d2_chg_cnt), 32'd2);
        d2_a = 6'h01; tick(); check("sat_c3", 32'(d2_chg_cnt), 32'd3);
        d2_a = 6'h00; tick(); check("sat_c4", 32'(d2_chg_cnt), 32'd3);
        d2_a = 6'h01; tick(); check("sat_c5", 32'(d2_chg_cnt), 32'd3);
        check("sat_q", 32'(d2_q), 32'h01);
        d2_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
